// File: rtl/lms_pkg.sv
// Shared constants, width derivations and FSM encoding for the
// serial complex LMS tap-update engine.
package lms_pkg;

    localparam int LMS_NUM_TAPS = 9;
    localparam int LMS_NBT_IN   = 8;
    localparam int LMS_NBF_IN   = 7;
    localparam int LMS_NBT_ERR  = 12;
    localparam int LMS_NBF_ERR  = 9;
    localparam int LMS_NBT_TAPS = 28;
    localparam int LMS_NBF_TAPS = 25;
    localparam int LMS_NBT_STEP = 12;
    localparam int LMS_NBF_STEP = 11;
    localparam int LMS_NBT_LEAK = 11;
    localparam int LMS_NBF_LEAK = 10;
    localparam int LMS_NB_GEAR  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } lms_state_e;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int prod_w(input int a, input int b);
        return a + b;
    endfunction

    // Adding two signed terms keeps one guard bit above the wider one.
    function automatic int sum_w(input int a, input int b);
        return max(a, b) + 1;
    endfunction

    function automatic int align_sh(input int f_to, input int f_from);
        return f_to - f_from;
    endfunction

    // Centre tap starts at unity gain.
    function automatic logic [63:0] tap_one(input int nbf);
        return 64'd1 << nbf;
    endfunction

endpackage

// File: rtl/lms_tap_mac.sv
// Combinational complex tap update: leak, error-times-sample
// correction, binary-point alignment, truncation and saturation.
module lms_tap_mac
    import lms_pkg::*;
#(
    parameter int NBT_IN   = LMS_NBT_IN,
    parameter int NBF_IN   = LMS_NBF_IN,
    parameter int NBT_ERR  = LMS_NBT_ERR,
    parameter int NBF_ERR  = LMS_NBF_ERR,
    parameter int NBT_TAPS = LMS_NBT_TAPS,
    parameter int NBF_TAPS = LMS_NBF_TAPS,
    parameter int NBT_STEP = LMS_NBT_STEP,
    parameter int NBF_STEP = LMS_NBF_STEP,
    parameter int NBT_LEAK = LMS_NBT_LEAK,
    parameter int NBF_LEAK = LMS_NBF_LEAK
) (
    input  logic [NBT_TAPS-1:0] tap_I_i,
    input  logic [NBT_TAPS-1:0] tap_Q_i,
    input  logic [NBT_IN-1:0]   x_I_i,
    input  logic [NBT_IN-1:0]   x_Q_i,
    input  logic [NBT_ERR-1:0]  err_I_i,
    input  logic [NBT_ERR-1:0]  err_Q_i,
    input  logic [NBT_STEP-1:0] step_i,
    input  logic [NBT_LEAK-1:0] leak_i,
    output logic [NBT_TAPS-1:0] new_I_o,
    output logic [NBT_TAPS-1:0] new_Q_o,
    output logic                sat_o
);

    localparam int W_EX  = prod_w(NBT_ERR, NBT_IN);
    localparam int F_EX  = NBF_ERR + NBF_IN;
    localparam int W_SUM = sum_w(W_EX, W_EX);
    localparam int W_UPD = prod_w(NBT_STEP, W_SUM);
    localparam int F_UPD = NBF_STEP + F_EX;
    localparam int W_SL  = prod_w(NBT_STEP, NBT_LEAK);
    localparam int F_SL  = NBF_STEP + NBF_LEAK;
    localparam int W_CO  = sum_w(W_SL, F_SL + 2);
    localparam int W_TC  = prod_w(NBT_TAPS, W_CO);
    localparam int F_TC  = NBF_TAPS + F_SL;
    localparam int F_AL  = max(F_TC, F_UPD);
    localparam int SH_TC = align_sh(F_AL, F_TC);
    localparam int SH_UP = align_sh(F_AL, F_UPD);
    localparam int W_ADD = sum_w(W_TC + SH_TC, W_UPD + SH_UP);
    localparam int SHR   = align_sh(F_AL, NBF_TAPS);

    localparam logic signed [W_CO-1:0] ONE =
        {{(W_CO-F_SL-1){1'b0}}, 1'b1, {F_SL{1'b0}}};

    logic signed [W_EX-1:0]  p_ii, p_qq, p_iq, p_qi;
    logic signed [W_SUM-1:0] s_i, s_q;
    logic signed [W_UPD-1:0] u_i, u_q;
    logic signed [W_SL-1:0]  sl;
    logic signed [W_CO-1:0]  co;
    logic signed [W_TC-1:0]  t_i, t_q;
    logic signed [W_ADD-1:0] a_i, a_q, r_i, r_q;
    logic                    sat_i, sat_q;

    function automatic logic [NBT_TAPS:0] clip(
        input logic signed [W_ADD-1:0] v
    );
        logic [NBT_TAPS:0] r;
        r = {1'b0, v[NBT_TAPS-1:0]};
        if (v[W_ADD-1] && !(&v[W_ADD-1:NBT_TAPS-1]))
            r = {1'b1, 1'b1, {(NBT_TAPS-1){1'b0}}};
        else if (!v[W_ADD-1] && (|v[W_ADD-1:NBT_TAPS-1]))
            r = {1'b1, 1'b0, {(NBT_TAPS-1){1'b1}}};
        return r;
    endfunction

    always_comb begin
        p_ii = W_EX'($signed(err_I_i)) * W_EX'($signed(x_I_i));
        p_qq = W_EX'($signed(err_Q_i)) * W_EX'($signed(x_Q_i));
        p_iq = W_EX'($signed(err_I_i)) * W_EX'($signed(x_Q_i));
        p_qi = W_EX'($signed(err_Q_i)) * W_EX'($signed(x_I_i));
        s_i  = W_SUM'(p_ii) + W_SUM'(p_qq);
        s_q  = W_SUM'(p_iq) - W_SUM'(p_qi);
        u_i  = W_UPD'($signed(step_i)) * W_UPD'(s_i);
        u_q  = W_UPD'($signed(step_i)) * W_UPD'(s_q);
        sl   = W_SL'($signed(step_i)) * W_SL'($signed(leak_i));
        co   = ONE - W_CO'(sl);
        t_i  = W_TC'($signed(tap_I_i)) * W_TC'(co);
        t_q  = W_TC'($signed(tap_Q_i)) * W_TC'(co);
        a_i  = (W_ADD'(t_i) <<< SH_TC) - (W_ADD'(u_i) <<< SH_UP);
        a_q  = (W_ADD'(t_q) <<< SH_TC) + (W_ADD'(u_q) <<< SH_UP);
        r_i  = a_i >>> SHR;
        r_q  = a_q >>> SHR;
        {sat_i, new_I_o} = clip(r_i);
        {sat_q, new_Q_o} = clip(r_q);
        sat_o = sat_i | sat_q;
    end

endmodule

// File: rtl/lms_serial_gear.sv
// Serial complex LMS tap updater: one tap per clock after each
// update request, with two-gear step schedule and sticky flags.
module lms_serial_gear
    import lms_pkg::*;
#(
    parameter int NUM_TAPS = LMS_NUM_TAPS,
    parameter int NBT_IN   = LMS_NBT_IN,
    parameter int NBF_IN   = LMS_NBF_IN,
    parameter int NBT_ERR  = LMS_NBT_ERR,
    parameter int NBF_ERR  = LMS_NBF_ERR,
    parameter int NBT_TAPS = LMS_NBT_TAPS,
    parameter int NBF_TAPS = LMS_NBF_TAPS,
    parameter int NBT_STEP = LMS_NBT_STEP,
    parameter int NBF_STEP = LMS_NBF_STEP,
    parameter int NBT_LEAK = LMS_NBT_LEAK,
    parameter int NBF_LEAK = LMS_NBF_LEAK,
    parameter int NB_GEAR  = LMS_NB_GEAR
) (
    input  logic                         clk,
    input  logic                         i_reset,
    input  logic                         i_en_rx,
    input  logic                         i_en_shtr,
    input  logic [NBT_IN-1:0]            i_is_data_I,
    input  logic [NBT_IN-1:0]            i_is_data_Q,
    input  logic [NBT_ERR-1:0]           i_err_I,
    input  logic [NBT_ERR-1:0]           i_err_Q,
    input  logic                         i_start,
    input  logic                         i_freeze,
    input  logic [NBT_STEP-1:0]          i_step0,
    input  logic [NBT_STEP-1:0]          i_step1,
    input  logic [NBT_LEAK-1:0]          i_leak,
    input  logic [NB_GEAR-1:0]           i_gear_len,
    output logic [NUM_TAPS*NBT_TAPS-1:0] o_taps_I,
    output logic [NUM_TAPS*NBT_TAPS-1:0] o_taps_Q,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_gear,
    output logic                         o_sat,
    output logic                         o_overrun
);

    localparam int KW = $clog2(NUM_TAPS);
    localparam logic [KW-1:0] K_LAST = KW'(NUM_TAPS - 1);
    localparam logic [NBT_TAPS-1:0] TAP_ONE =
        NBT_TAPS'(tap_one(NBF_TAPS));

    lms_state_e state_q, state_d;

    logic [KW-1:0]       k_q;
    logic [NB_GEAR-1:0]  gear_q;
    logic                sat_q;
    logic                ovr_q;
    logic [NBT_ERR-1:0]  e_I_q, e_Q_q;
    logic [NBT_STEP-1:0] step_q;
    logic [NBT_LEAK-1:0] leak_q;

    logic [NBT_IN-1:0]   sh_I_q [NUM_TAPS];
    logic [NBT_IN-1:0]   sh_Q_q [NUM_TAPS];
    logic [NBT_IN-1:0]   sn_I_q [NUM_TAPS];
    logic [NBT_IN-1:0]   sn_Q_q [NUM_TAPS];
    logic [NBT_TAPS-1:0] tap_I_q [NUM_TAPS];
    logic [NBT_TAPS-1:0] tap_Q_q [NUM_TAPS];

    logic                rst;
    logic                accept;
    logic [NBT_TAPS-1:0] new_I, new_Q;
    logic                mac_sat;

    assign rst    = i_reset | ~i_en_rx;
    assign accept = (state_q == ST_IDLE) & i_start & ~i_freeze;
    assign o_gear = (gear_q >= i_gear_len);
    assign o_sat     = sat_q;
    assign o_overrun = ovr_q;

    always_comb begin
        state_d = state_q;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept)
                    state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                o_busy = 1'b1;
                if (k_q == K_LAST)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                o_busy  = 1'b1;
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            gear_q  <= '0;
            sat_q   <= 1'b0;
            ovr_q   <= 1'b0;
            e_I_q   <= '0;
            e_Q_q   <= '0;
            step_q  <= '0;
            leak_q  <= '0;
            for (int m = 0; m < NUM_TAPS; m++) begin
                sh_I_q[m]  <= '0;
                sh_Q_q[m]  <= '0;
                sn_I_q[m]  <= '0;
                sn_Q_q[m]  <= '0;
                tap_I_q[m] <= (m == NUM_TAPS / 2) ? TAP_ONE : '0;
                tap_Q_q[m] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (i_en_shtr) begin
                sh_I_q[0] <= i_is_data_I;
                sh_Q_q[0] <= i_is_data_Q;
                for (int m = 1; m < NUM_TAPS; m++) begin
                    sh_I_q[m] <= sh_I_q[m-1];
                    sh_Q_q[m] <= sh_Q_q[m-1];
                end
            end
            if (i_start && o_busy)
                ovr_q <= 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        sn_I_q <= sh_I_q;
                        sn_Q_q <= sh_Q_q;
                        e_I_q  <= i_err_I;
                        e_Q_q  <= i_err_Q;
                        step_q <= o_gear ? i_step1 : i_step0;
                        leak_q <= i_leak;
                        k_q    <= '0;
                    end
                end
                ST_UPDATE: begin
                    tap_I_q[k_q] <= new_I;
                    tap_Q_q[k_q] <= new_Q;
                    if (mac_sat)
                        sat_q <= 1'b1;
                    k_q <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
                end
                ST_DONE: begin
                    if (!(&gear_q))
                        gear_q <= gear_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Only tap k's own registered value feeds the MAC.
    lms_tap_mac #(
        .NBT_IN   (NBT_IN),
        .NBF_IN   (NBF_IN),
        .NBT_ERR  (NBT_ERR),
        .NBF_ERR  (NBF_ERR),
        .NBT_TAPS (NBT_TAPS),
        .NBF_TAPS (NBF_TAPS),
        .NBT_STEP (NBT_STEP),
        .NBF_STEP (NBF_STEP),
        .NBT_LEAK (NBT_LEAK),
        .NBF_LEAK (NBF_LEAK)
    ) u_mac (
        .tap_I_i (tap_I_q[k_q]),
        .tap_Q_i (tap_Q_q[k_q]),
        .x_I_i   (sn_I_q[k_q]),
        .x_Q_i   (sn_Q_q[k_q]),
        .err_I_i (e_I_q),
        .err_Q_i (e_Q_q),
        .step_i  (step_q),
        .leak_i  (leak_q),
        .new_I_o (new_I),
        .new_Q_o (new_Q),
        .sat_o   (mac_sat)
    );

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_flat
        assign o_taps_I[g*NBT_TAPS +: NBT_TAPS] = tap_I_q[g];
        assign o_taps_Q[g*NBT_TAPS +: NBT_TAPS] = tap_Q_q[g];
    end

endmodule

// File: doc/lms_serial_gear.md
Name: lms_serial_gear

Overview:
- Next-generation complex LMS tap-update engine for the fractionally spaced equaliser (FSE), with runtime-programmable step, leak and two-gear step schedule.
- Replaces the fully parallel per-tap update with one time-multiplexed complex tap MAC that updates taps serially, one tap per clock, after each baud-rate update request.
- Sits beside the FSE filter: it takes the rate-2 input samples and the slicer error, and drives the flat tap buses back into the filter.

Parameters:
- NUM_TAPS, 9: number of complex taps (odd, ≥3)
- NBT_IN / NBF_IN, 8 / 7: input sample format S(8,7)
- NBT_ERR / NBF_ERR, 12 / 9: error format S(12,9)
- NBT_TAPS / NBF_TAPS, 28 / 25: tap format S(28,25)
- NBT_STEP / NBF_STEP, 12 / 11: step format S(12,11)
- NBT_LEAK / NBF_LEAK, 11 / 10: leak format S(11,10)
- NB_GEAR, 16: gear counter width

Ports:
- clk, in, 1: clock
- i_reset, in, 1: reset, synchronous, active-high, on clock clk
- i_en_rx, in, 1: receiver enable; when low, acts as reset
- i_en_shtr, in, 1: rate-2 shift enable
- i_is_data_I / i_is_data_Q, in, NBT_IN: input samples
- i_err_I / i_err_Q, in, NBT_ERR: slicer error
- i_start, in, 1: update request pulse
- i_freeze, in, 1: ignore update requests
- i_step0 / i_step1, in, NBT_STEP: step for gear 0 and gear 1
- i_leak, in, NBT_LEAK: leak factor
- i_gear_len, in, NB_GEAR: number of completed updates before switching to gear 1
- o_taps_I / o_taps_Q, out, NUM_TAPS*NBT_TAPS: tap m in bits [(m+1)*NBT_TAPS-1 : m*NBT_TAPS]
- o_busy, out, 1: update in progress
- o_done, out, 1: one-cycle pulse when an update completes
- o_gear, out, 1: current gear
- o_sat, out, 1: sticky, a tap saturated
- o_overrun, out, 1: sticky, i_start arrived while busy

Behaviour:
Reset (i_reset=1 or i_en_rx=0, synchronous):
- Shifter and snapshot cleared; every tap 0 except tap_I[NUM_TAPS/2] = 1.0, which is 0x2000000 at default widths.
- FSM returns to IDLE; gear counter = 0.
- o_busy, o_done, o_sat, o_overrun = 0.
- o_gear = (i_gear_len==0).
- Reset during UPDATE aborts it: no o_done, and taps go to their init values.

Shifter:
- When i_en_shtr=1: sample enters position 0 and positions shift up by one.
- Otherwise the shifter holds.

FSM states IDLE, UPDATE, DONE:
- IDLE→UPDATE when i_start=1 and i_freeze=0. On that edge:
  - snapshot shifter to the buffer;
  - latch i_err_I/Q;
  - latch step = o_gear ? i_step1 : i_step0;
  - latch i_leak;
  - k=0.
- UPDATE: each edge writes tap k from the snapshot, then k++.
  - The tap MAC reads only tap k's registered value, so partial updates never feed other taps.
  - After k=NUM_TAPS-1 is written → DONE.
  - i_en_shtr may keep shifting during UPDATE; the snapshot is unaffected.
- DONE: o_done=1 for one cycle; gear counter increments, saturating at all-ones; → IDLE.
- o_busy=1 in UPDATE and DONE.

Timing:
- Start sampled at edge t: tap k is written at edge t+1+k.
- o_done is high in the cycle after edge t+NUM_TAPS.
- The next i_start is accepted in IDLE at the earliest.
- i_start while o_busy=1: request is dropped and o_overrun is set.
- i_start while i_freeze=1: request is dropped silently.

Gear:
- o_gear = (gear counter ≥ i_gear_len).
- The comparison is combinational on the registered counter.
- The new gear applies from the next accepted start.

Arithmetic (full precision):
- one = 1<<(NBF_STEP+NBF_LEAK)
- tap_I' = tap_I*(one − step*leak) − step*(eI*xI + eQ*xQ)
- tap_Q' = tap_Q*(one − step*leak) + step*(eI*xQ − eQ*xI)
- The guard bit on the sum of products is kept.
- Align binary points, add with one extra bit, truncate LSBs to NBF_TAPS.
- Saturate to [−2^(NBT_TAPS−1), 2^(NBT_TAPS−1)−1]; any saturation sets o_sat.

Decomposition:
- lms_pkg holds:
  - the max() function;
  - term/add width and alignment localparam derivations;
  - the centre-tap init constant;
  - the FSM state encoding.
- One sub-module, lms_tap_mac: combinational complex tap update with leak, alignment and saturation. It outputs new_I, new_Q and a sat flag, and is instantiated once.

Test Plan:
- Reset check → tap_I[4]=0x2000000, all other taps 0; o_gear=0 with i_gear_len=2.
- Update with step0=0x400, leak=0, eI=0x200, eQ=0, all xI=0x40, xQ=0:
  - tap_I[4] → 0x1800000, other tap_I → 0xF800000, tap_Q unchanged;
  - o_done exactly NUM_TAPS+1 cycles after the start edge.
- i_gear_len=2, step1=0: third update leaves all taps unchanged; o_gear rises after the 2nd o_done.
- Repeated updates with eI=0x7FF, xI=0x7F, step0=0x7FF:
  - tap_I clamps at 0x8000000 and o_sat=1;
  - after i_reset, o_sat=0.
- i_start pulsed 3 cycles after an accepted start → o_overrun=1, exactly one o_done.
- i_start with i_freeze=1 → no update and o_overrun stays 0.
- i_en_rx dropped at k=4 → taps return to init and o_done never fires.
